// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: M-extension op encodings, mul/div FSM states, sign helpers.
package riscv_pkg;

   typedef enum logic [2:0] {
      OpMul    = 3'b000,
      OpMulh   = 3'b001,
      OpMulhsu = 3'b010,
      OpMulhu  = 3'b011,
      OpDiv    = 3'b100,
      OpDivu   = 3'b101,
      OpRem    = 3'b110,
      OpRemu   = 3'b111
   } muldiv_op_e;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StCalc = 2'd1,
      StDone = 2'd2
   } muldiv_state_e;

   localparam int unsigned MULDIV_ITER = 32;

   // op_a is treated as signed by these ops (MUL is sign-agnostic in its low half).
   function automatic logic op_signed_a(input muldiv_op_e op);
      return (op == OpMulh) || (op == OpMulhsu) || (op == OpDiv) || (op == OpRem);
   endfunction

   function automatic logic op_signed_b(input muldiv_op_e op);
      return (op == OpMulh) || (op == OpDiv) || (op == OpRem);
   endfunction

   // Turn the unsigned magnitude result held in acc back into the signed M-extension result.
   // Multiply: acc is the 64-bit product. Divide: acc = {remainder, quotient}.
   function automatic logic [31:0] muldiv_fixup(input muldiv_op_e op, input logic sign_a,
                                                input logic sign_b, input logic [63:0] acc);
      logic [63:0] prod;
      logic [31:0] quo;
      logic [31:0] rem;
      logic [31:0] res;
      prod = (sign_a ^ sign_b) ? -acc : acc;
      quo  = (sign_a ^ sign_b) ? -acc[31:0] : acc[31:0];
      rem  = sign_a ? -acc[63:32] : acc[63:32];
      unique case (op)
         OpMul:                      res = prod[31:0];
         OpMulh, OpMulhsu, OpMulhu:  res = prod[63:32];
         OpDiv, OpDivu:              res = quo;
         default:                    res = rem;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide, one bit per cycle.
module muldiv_unit
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam logic [5:0] LastIter = 6'(MULDIV_ITER - 1);

   muldiv_state_e state_q, state_d;
   muldiv_op_e    op_q, op_d, op_in;
   logic [5:0]    cnt_q, cnt_d;
   logic [63:0]   acc_q, acc_d, acc_step;
   logic [31:0]   opr_q, opr_d;
   logic          sa_q, sa_d, sb_q, sb_d;
   logic [31:0]   result_q, result_d;

   logic          accept, div_zero, div_ovf, special;
   logic [31:0]   special_res, mag_a, mag_b;
   logic          in_sa, in_sb;
   logic [32:0]   mul_sum, div_part, div_diff;
   logic [63:0]   div_shift;

   assign op_in  = muldiv_op_e'(funct3);
   assign accept = (state_q == StIdle) && start;

   // Divide special cases resolved at accept time, skipping the iteration loop.
   always_comb begin
      div_zero    = (op_b == 32'h0);
      div_ovf     = ((op_in == OpDiv) || (op_in == OpRem)) &&
                    (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
      special     = funct3[2] && (div_zero || div_ovf);
      special_res = 32'h0;
      if (div_zero) begin
         special_res = ((op_in == OpDiv) || (op_in == OpDivu)) ? 32'hFFFF_FFFF : op_a;
      end else if (op_in == OpDiv) begin
         special_res = 32'h8000_0000;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = special ? StDone : StCalc;
         StCalc:  if (cnt_q == LastIter) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs.
   always_comb begin
      busy = (state_q != StIdle);
      done = (state_q == StDone);
   end

   // One iteration: multiply adds the multiplicand on acc[0] then shifts right; divide shifts
   // left and subtracts the divisor when it fits (restoring).
   always_comb begin
      mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opr_q} : 33'h0);
      div_shift = {acc_q[62:0], 1'b0};
      div_part  = {acc_q[63], div_shift[63:32]};
      div_diff  = div_part - {1'b0, opr_q};
      if (!op_q[2]) begin
         acc_step = {mul_sum, acc_q[31:1]};
      end else if (!div_diff[32]) begin
         acc_step = {div_diff[31:0], div_shift[31:1], 1'b1};
      end else begin
         acc_step = div_shift;
      end
   end

   // Datapath next-state: load magnitudes on accept, iterate in CALC, write result entering DONE.
   always_comb begin
      op_d     = op_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opr_d    = opr_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      result_d = result_q;
      in_sa    = op_signed_a(op_in) && op_a[31];
      in_sb    = op_signed_b(op_in) && op_b[31];
      mag_a    = in_sa ? -op_a : op_a;
      mag_b    = in_sb ? -op_b : op_b;
      if (accept) begin
         op_d  = op_in;
         cnt_d = 6'd0;
         sa_d  = in_sa;
         sb_d  = in_sb;
         // Multiplier / dividend sit in the low half of acc; opr holds multiplicand / divisor.
         acc_d = {32'h0, funct3[2] ? mag_a : mag_b};
         opr_d = funct3[2] ? mag_b : mag_a;
         if (special) result_d = special_res;
      end else if (state_q == StCalc) begin
         cnt_d = cnt_q + 6'd1;
         acc_d = acc_step;
         if (cnt_q == LastIter) result_d = muldiv_fixup(op_q, sa_q, sb_q, acc_step);
      end
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q     <= OpMul;
         cnt_q    <= 6'd0;
         acc_q    <= 64'h0;
         opr_q    <= 32'h0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         result_q <= 32'h0;
      end else begin
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opr_q    <= opr_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         result_q <= result_d;
      end
   end

   assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table plus hand-written multi-cycle sequences.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] op_a, op_b;
   logic        busy, done;
   logic [31:0] result;

   int n_cmp = 0;
   int n_bad = 0;

   muldiv_unit #(.XLEN(32)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .funct3 (funct3),
      .op_a   (op_a),
      .op_b   (op_b),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   localparam int NV = 20;
   vec_t vecs[NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Issue one op from the IDLE cycle; returns result and the cycle (after start) of done.
   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output logic busy_ok);
      @(negedge clk);
      start = 1'b1; funct3 = f; op_a = a; op_b = b;
      @(negedge clk);
      start = 1'b0;
      lat = -1; busy_ok = 1'b1; res = 32'hx;
      for (int k = 1; k <= 40 && lat < 0; k++) begin
         if (!busy) busy_ok = 1'b0;
         if (done) begin
            lat = k;
            res = result;
         end else begin
            @(negedge clk);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] res;
      int          lat, dones;
      logic        bok;

      vecs[0]  = '{"mul_7x6",      3'b000, 32'd7,         32'd6,         32'h0000_002A, 33};
      vecs[1]  = '{"mulh_m1m1",    3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33};
      vecs[2]  = '{"mulhu_m1m1",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
      vecs[3]  = '{"mulhsu_m1x2",  3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33};
      vecs[4]  = '{"div_m7_2",     3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33};
      vecs[5]  = '{"rem_m7_2",     3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33};
      vecs[6]  = '{"divu_100_7",   3'b101, 32'd100,       32'd7,         32'd14,        33};
      vecs[7]  = '{"remu_100_7",   3'b111, 32'd100,       32'd7,         32'd2,         33};
      vecs[8]  = '{"div_5_0",      3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
      vecs[9]  = '{"remu_5_0",     3'b111, 32'd5,         32'd0,         32'd5,         1};
      vecs[10] = '{"div_ovf",      3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
      vecs[11] = '{"rem_ovf",      3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
      vecs[12] = '{"mul_m3x5",     3'b000, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1, 33};
      vecs[13] = '{"mulh_min_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
      vecs[14] = '{"divu_max_1",   3'b101, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33};
      vecs[15] = '{"div_7_m2",     3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
      vecs[16] = '{"rem_7_m2",     3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         33};
      vecs[17] = '{"divu_5_0",     3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
      vecs[18] = '{"div_min_2",    3'b100, 32'h8000_0000, 32'd2,         32'hC000_0000, 33};
      vecs[19] = '{"divu_min_m1",  3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33};

      rst = 1'b1; start = 1'b0; funct3 = 3'b000; op_a = 32'h0; op_b = 32'h0;
      repeat (3) @(negedge clk);
      check("reset_busy", {31'h0, busy}, 32'h0);
      check("reset_done", {31'h0, done}, 32'h0);
      check("reset_result", result, 32'h0);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         run_op(vecs[i].f, vecs[i].a, vecs[i].b, res, lat, bok);
         check({vecs[i].name, "_result"}, res, vecs[i].exp);
         check({vecs[i].name, "_latency"}, 32'(lat), 32'(vecs[i].lat));
         check({vecs[i].name, "_busy"}, {31'h0, bok}, 32'h1);
         @(negedge clk);
         check({vecs[i].name, "_idle_after"}, {30'h0, busy, done}, 32'h0);
         check({vecs[i].name, "_result_held"}, result, vecs[i].exp);
      end

      // start held high with operands changing during CALC: only the first request counts.
      @(negedge clk);
      start = 1'b1; funct3 = 3'b000; op_a = 32'd11; op_b = 32'd13;
      dones = 0; lat = -1;
      for (int k = 1; k <= 34; k++) begin
         @(negedge clk);
         op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom_range(0, 7));
         if (done) begin
            dones++;
            lat = k;
            res = result;
         end
      end
      // start was high across the DONE edge; that request must not have been accepted.
      check("hold_busy_after_done", {31'h0, busy}, 32'h0);
      start = 1'b0;
      check("hold_done_count", 32'(dones), 32'd1);
      check("hold_latency", 32'(lat), 32'd33);
      check("hold_result", res, 32'd143);
      @(negedge clk);
      check("hold_still_idle", {31'h0, busy}, 32'h0);

      // Reset during iteration 10 aborts the op.
      @(negedge clk);
      start = 1'b1; funct3 = 3'b011; op_a = 32'h1234_5678; op_b = 32'h9ABC_DEF0;
      @(negedge clk);
      start = 1'b0;
      dones = 0;
      for (int k = 1; k < 10; k++) begin
         if (done) dones++;
         @(negedge clk);
      end
      if (done) dones++;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", {31'h0, busy}, 32'h0);
      check("abort_done", {31'h0, done}, 32'h0);
      check("abort_result", result, 32'h0);
      for (int k = 0; k < 40; k++) begin
         if (done) dones++;
         @(negedge clk);
      end
      check("abort_no_done", 32'(dones), 32'd0);

      run_op(3'b000, 32'd3, 32'd3, res, lat, bok);
      check("post_reset_mul_result", res, 32'd9);
      check("post_reset_mul_latency", 32'(lat), 32'd33);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
